// File: rtl/input_port_vc_controller.sv
// input_port_vc_controller: one router input port with per-VC circular flit buffers and XY route
//    computation. Each VC runs IDLE -> RC -> VA -> SA and then requests switch slots until its tail leaves.
// Ports: clk/rst (synchronous, active-low); data_i/valid_flit_i incoming flits; on_off_o/idle_o per-VC status;
//    vc_request_o/out_port_o/vc_valid_i/vc_new_i VC allocation; switch_request_o/sa_grant_i switch allocation;
//    flit_o/valid_flit_o departing flit, one cycle after its grant; error_o registered protocol-violation pulse.
module input_port_vc_controller #(
   parameter int  VC_NUM      = 2,
   parameter int  BUFFER_SIZE = 8,
   parameter int  X_CURRENT   = 0,
   parameter int  Y_CURRENT   = 0,
   parameter int  COORD_W     = 2,
   parameter int  PAYLOAD_W   = 16,
   localparam int VC_SIZE     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   localparam int FLIT_W      = 2 + VC_SIZE + 2*COORD_W + PAYLOAD_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [FLIT_W-1:0]              data_i,
   input  logic                           valid_flit_i,
   output logic [VC_NUM-1:0]              on_off_o,
   output logic [VC_NUM-1:0]              idle_o,
   output logic [VC_NUM-1:0]              vc_request_o,
   output logic [VC_NUM-1:0][2:0]         out_port_o,
   input  logic [VC_NUM-1:0]              vc_valid_i,
   input  logic [VC_NUM-1:0][VC_SIZE-1:0] vc_new_i,
   output logic [VC_NUM-1:0]              switch_request_o,
   input  logic [VC_NUM-1:0]              sa_grant_i,
   output logic [FLIT_W-1:0]              flit_o,
   output logic                           valid_flit_o,
   output logic                           error_o
);
   localparam int PTR_W  = $clog2(BUFFER_SIZE);
   localparam int CNT_W  = PTR_W + 1;
   localparam int DY_LSB = PAYLOAD_W;
   localparam int DX_LSB = PAYLOAD_W + COORD_W;
   localparam int VC_LSB = PAYLOAD_W + 2*COORD_W;
   localparam int TY_LSB = VC_LSB + VC_SIZE;

   localparam logic [2:0] P_LOCAL = 3'd0;
   localparam logic [2:0] P_NORTH = 3'd1;
   localparam logic [2:0] P_SOUTH = 3'd2;
   localparam logic [2:0] P_WEST  = 3'd3;
   localparam logic [2:0] P_EAST  = 3'd4;

   typedef enum logic [1:0] {IDLE, RC, VA, SA} state_t;

   logic [FLIT_W-1:0]  mem [VC_NUM][BUFFER_SIZE];
   logic [PTR_W-1:0]   rd_ptr [VC_NUM];
   logic [PTR_W-1:0]   wr_ptr [VC_NUM];
   logic [CNT_W-1:0]   count [VC_NUM];
   state_t             state_q [VC_NUM];
   state_t             state_d [VC_NUM];
   logic [VC_SIZE-1:0] vc_new_q [VC_NUM];

   logic [FLIT_W-1:0]  front [VC_NUM];
   logic [FLIT_W-1:0]  front_out [VC_NUM];
   logic [2:0]         route [VC_NUM];
   logic [VC_NUM-1:0]  sel, push, pop;
   logic [VC_SIZE-1:0] wr_vc;
   logic [1:0]         wr_type;
   logic               wr_head, wr_vc_ok, multi_grant, err_d;
   int                 wr_vc_int, dx, dy;

   always_comb begin
      wr_vc       = data_i[VC_LSB +: VC_SIZE];
      wr_type     = data_i[TY_LSB +: 2];
      wr_head     = (wr_type == 2'b00) || (wr_type == 2'b11);
      wr_vc_int   = 32'(wr_vc);
      wr_vc_ok    = wr_vc_int < VC_NUM;
      multi_grant = $countones(sa_grant_i) > 1;
      err_d       = (valid_flit_i && !wr_vc_ok) || multi_grant;
      dx          = 0;
      dy          = 0;
      for (int v = 0; v < VC_NUM; v++) begin
         front[v]     = mem[v][rd_ptr[v]];
         front_out[v] = front[v];
         front_out[v][VC_LSB +: VC_SIZE] = vc_new_q[v];

         idle_o[v]           = (state_q[v] == IDLE) && (count[v] == '0);
         on_off_o[v]         = count[v] <= CNT_W'(BUFFER_SIZE - 2);
         vc_request_o[v]     = (state_q[v] == VA);
         switch_request_o[v] = (state_q[v] == SA) && (count[v] != '0);

         // A multi-bit grant is rejected as a whole, so no VC pops.
         pop[v]  = sa_grant_i[v] && switch_request_o[v] && !multi_grant;
         sel[v]  = valid_flit_i && wr_vc_ok && (wr_vc == VC_SIZE'(v));
         // A full buffer still accepts a write when the same edge frees a slot.
         push[v] = sel[v] && ((count[v] != CNT_W'(BUFFER_SIZE)) || pop[v]);

         if (sel[v] && !push[v])                          err_d = 1'b1;
         if (sa_grant_i[v] && !switch_request_o[v])       err_d = 1'b1;
         if (push[v] && wr_head && (state_q[v] != IDLE))  err_d = 1'b1;

         // Dimension-ordered XY routing from the flit at the buffer front.
         dx = 32'(front[v][DX_LSB +: COORD_W]);
         dy = 32'(front[v][DY_LSB +: COORD_W]);
         if (dx > X_CURRENT)      route[v] = P_EAST;
         else if (dx < X_CURRENT) route[v] = P_WEST;
         else if (dy > Y_CURRENT) route[v] = P_SOUTH;
         else if (dy < Y_CURRENT) route[v] = P_NORTH;
         else                     route[v] = P_LOCAL;
      end
   end

   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         state_d[v] = state_q[v];
         case (state_q[v])
            IDLE:    if (push[v] && wr_head) state_d[v] = RC;
            RC:      state_d[v] = VA;
            VA:      if (vc_valid_i[v]) state_d[v] = SA;
            // Type MSB set means TAIL or HEADTAIL: the packet ends with this pop.
            SA:      if (pop[v] && front[v][TY_LSB+1]) state_d[v] = IDLE;
            default: state_d[v] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int v = 0; v < VC_NUM; v++) begin
            state_q[v]    <= IDLE;
            rd_ptr[v]     <= '0;
            wr_ptr[v]     <= '0;
            count[v]      <= '0;
            out_port_o[v] <= '0;
            vc_new_q[v]   <= '0;
         end
         flit_o       <= '0;
         valid_flit_o <= 1'b0;
         error_o      <= 1'b0;
      end else begin
         error_o      <= err_d;
         valid_flit_o <= |pop;
         for (int v = 0; v < VC_NUM; v++) begin
            state_q[v] <= state_d[v];
            count[v]   <= count[v] + CNT_W'(push[v]) - CNT_W'(pop[v]);
            if (push[v]) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
            if (pop[v]) begin
               rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
               flit_o    <= front_out[v];
            end
            if (state_q[v] == RC) out_port_o[v] <= route[v];
            if ((state_q[v] == VA) && vc_valid_i[v]) vc_new_q[v] <= vc_new_i[v];
         end
      end
   end

   // Storage needs no reset: emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      for (int v = 0; v < VC_NUM; v++) begin
         if (rst && push[v]) mem[v][wr_ptr[v]] <= data_i;
      end
   end
endmodule
